cps_display_driver: RTL and testbench
=====================================

Name: cps_display_driver

Overview:
- Downstream stage of the car parking system controller.
- Takes the controller's 3-bit status code and drives a 4-digit, common-anode, multiplexed seven-segment display through `display[6:0]` and `anodeActivate[3:0]`.
- Owns the refresh divider, the digit scan sequence, frame-aligned status latching and the message glyph ROM.
- Optional blinking of the error message.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit is held active; legal range ≥1.
- BLINK_DIV, 32, full scan frames per blink half-period; legal range ≥1; used only with CPS_BLINK_EN.

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  synchronous, active-high reset
- status  input  3  controller state code: 0 IDLE, 1 WAIT_PASS, 2 WRONG_PASS, 3 RIGHT_PASS, 4 STOP, 5-7 reserved
- display  output  7  segment drive, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
- anodeActivate  output  4  digit enable, active-low, at most one bit low; bit3 = leftmost character
- frameStart  output  1  one-cycle pulse on the cycle the latched status updates (scan wraps 3->0)

Behaviour:
- Reset: synchronous, active-high, on the Clk rising edge; polarity and synchronicity are fixed.
  - On reset: refreshCnt=0, digitIdx=0, latchedStatus=0 (IDLE), blinkCnt=0, blinkPhase=visible.
  - Reset output values: display=7'b1111111, anodeActivate=4'b1111, frameStart=0.
  - Rst asserted mid-frame returns every register and output to its reset value on that edge.
- Refresh counter:
  - refreshCnt counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and digitIdx advances 0->1->2->3->0.
- Frame boundary: the advance where digitIdx goes 3->0.
  - latchedStatus <= status.
  - frameStart pulses for 1 cycle, coincident with digitIdx becoming 0.
  - Status changes mid-frame are ignored until the next boundary, so the display never tears.
- Output registers: `anodeActivate` and `display` are registered from (digitIdx, latchedStatus), with 1-cycle latency.
  - digitIdx=k drives anodeActivate = all ones except bit k = 0.
  - display = glyph of character k of the message.
  - Character index 3 is the leftmost.
  - First post-reset cycle: anodeActivate=4'b1110, display = char 0 of IDLE.
- Messages, left to right:
  - IDLE "    "
  - WAIT_PASS "EntP"
  - WRONG_PASS "Err "
  - RIGHT_PASS "Go  "
  - STOP "StOP"
  - reserved "----"
- Glyphs (a..g):
  - E=0110000, n=1101010, t=1110000, P=0011000
  - r=1111010, G=0100001, o=1100010, S=0100100
  - O=0000001, -=1111110, blank=1111111
- REFRESH_DIV=1: digitIdx advances every cycle and a frame is 4 cycles.
- No handshake: status is sampled only at frame boundaries and needs no valid strobe.

Optional Feature:
- Macro: CPS_BLINK_EN.
- Defined:
  - blinkCnt counts frames 0..BLINK_DIV-1; on wrap, blinkPhase toggles.
  - While latchedStatus==WRONG_PASS and blinkPhase=hidden, display=1111111; anodes keep scanning normally.
  - When latchedStatus changes at a boundary: blinkCnt=0, blinkPhase=visible.
  - Other statuses are always visible.
- Not defined: blinkCnt and blinkPhase are absent; WRONG_PASS displays steadily.

Test Plan:
- REFRESH_DIV=2, status=0, Rst high 3 cycles then low → after the reset edge display=1111111, anodeActivate=1111; the next cycles show anodes 1110,1110,1101,1101,1011,1011,0111,0111 repeating, display=1111111 throughout.
- REFRESH_DIV=2, status=1 applied mid-frame 0 → the current frame stays blank; after the frameStart pulse, anodes 0111/1011/1101/1110 show 0110000/1101010/1110000/0011000 ("EntP").
- status=4 → frame shows S,t,O,P = 0100100,1110000,0000001,0011000; status=6 → all digits 1111110.
- status switches 3→2→3 within one frame → never displayed as 2; the next frame shows "Go  " (0100001,1100010,blank,blank).
- Rst asserted while digitIdx=2 → next edge anodeActivate=1111, display=1111111, latchedStatus=IDLE; scan restarts at digit 0.
- CPS_BLINK_EN, BLINK_DIV=2, REFRESH_DIV=1, status=2 → frames alternate 2 visible ("Err ") / 2 blank (display=1111111, anodes scanning); without the macro → "Err " every frame.

Source files
------------

// File: rtl/cps_display_driver.sv
// Car-park status to 4-digit common-anode seven-segment scan driver; outputs registered one cycle after scan state.
// Optional CPS_BLINK_EN macro blinks the "Err " message at a BLINK_DIV-frame half-period.
module cps_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 32
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [2:0] status,
  output logic [6:0] display,
  output logic [3:0] anodeActivate,
  output logic       frameStart
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [6:0] G_E     = 7'b0110000;
  localparam logic [6:0] G_N     = 7'b1101010;
  localparam logic [6:0] G_T     = 7'b1110000;
  localparam logic [6:0] G_P     = 7'b0011000;
  localparam logic [6:0] G_R     = 7'b1111010;
  localparam logic [6:0] G_G     = 7'b0100001;
  localparam logic [6:0] G_O_LO  = 7'b1100010;
  localparam logic [6:0] G_S     = 7'b0100100;
  localparam logic [6:0] G_O_UP  = 7'b0000001;
  localparam logic [6:0] G_DASH  = 7'b1111110;
  localparam logic [6:0] G_BLANK = 7'b1111111;

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic [2:0]    latched_status_q, latched_status_d;
  logic [6:0]    display_q, display_d;
  logic [3:0]    anode_q, anode_d;
  logic          frame_start_q, frame_start_d;
  logic          digit_tick;
  logic          frame_wrap;
  logic          hide;

  // Character k of the message, k=3 being the leftmost.
  function automatic logic [6:0] glyph(input logic [2:0] st, input logic [1:0] k);
    logic [6:0] g;
    g = G_BLANK;
    case (st)
      3'd0: g = G_BLANK;
      3'd1: case (k)
              2'd3: g = G_E;
              2'd2: g = G_N;
              2'd1: g = G_T;
              default: g = G_P;
            endcase
      3'd2: case (k)
              2'd3: g = G_E;
              2'd2: g = G_R;
              2'd1: g = G_R;
              default: g = G_BLANK;
            endcase
      3'd3: case (k)
              2'd3: g = G_G;
              2'd2: g = G_O_LO;
              default: g = G_BLANK;
            endcase
      3'd4: case (k)
              2'd3: g = G_S;
              2'd2: g = G_T;
              2'd1: g = G_O_UP;
              default: g = G_P;
            endcase
      default: g = G_DASH;
    endcase
    return g;
  endfunction

  assign digit_tick = (refresh_cnt_q == RW'(REFRESH_DIV - 1));
  assign frame_wrap = digit_tick && (digit_idx_q == 2'd3);

`ifdef CPS_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_hidden_q, blink_hidden_d;

  always_comb begin
    blink_cnt_d    = blink_cnt_q;
    blink_hidden_d = blink_hidden_q;
    if (frame_wrap) begin
      // A new message always starts in its visible half-period.
      if (status != latched_status_q) begin
        blink_cnt_d    = '0;
        blink_hidden_d = 1'b0;
      end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d    = '0;
        blink_hidden_d = ~blink_hidden_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      blink_cnt_q    <= '0;
      blink_hidden_q <= 1'b0;
    end else begin
      blink_cnt_q    <= blink_cnt_d;
      blink_hidden_q <= blink_hidden_d;
    end
  end

  assign hide = blink_hidden_q && (latched_status_q == 3'd2);
`else
  // Without blinking nothing is hidden; BLINK_DIV is referenced only for legal-range sanity.
  assign hide = (BLINK_DIV < 1);
`endif

  always_comb begin
    refresh_cnt_d    = digit_tick ? '0 : refresh_cnt_q + 1'b1;
    digit_idx_d      = digit_tick ? digit_idx_q + 2'd1 : digit_idx_q;
    latched_status_d = frame_wrap ? status : latched_status_q;
    frame_start_d    = frame_wrap;
    anode_d          = ~(4'b0001 << digit_idx_q);
    display_d        = hide ? G_BLANK : glyph(latched_status_q, digit_idx_q);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      refresh_cnt_q    <= '0;
      digit_idx_q      <= 2'd0;
      latched_status_q <= 3'd0;
      frame_start_q    <= 1'b0;
      anode_q          <= 4'b1111;
      display_q        <= G_BLANK;
    end else begin
      refresh_cnt_q    <= refresh_cnt_d;
      digit_idx_q      <= digit_idx_d;
      latched_status_q <= latched_status_d;
      frame_start_q    <= frame_start_d;
      anode_q          <= anode_d;
      display_q        <= display_d;
    end
  end

  assign display       = display_q;
  assign anodeActivate = anode_q;
  assign frameStart    = frame_start_q;

endmodule

// File: tb/tb_cps_display_driver.sv
// Bench for cps_display_driver: two instances (REFRESH_DIV=2 and REFRESH_DIV=1/BLINK_DIV=2) checked tick by tick from a queue of expected outputs.
module tb_cps_display_driver;

  logic       Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst_a, rst_b;
  logic [2:0] st_a, st_b;
  logic [6:0] disp_a, disp_b;
  logic [3:0] an_a, an_b;
  logic       fs_a, fs_b;

  cps_display_driver #(.REFRESH_DIV(2), .BLINK_DIV(2)) u_a (
    .Clk(Clk), .Rst(rst_a), .status(st_a),
    .display(disp_a), .anodeActivate(an_a), .frameStart(fs_a)
  );

  cps_display_driver #(.REFRESH_DIV(1), .BLINK_DIV(2)) u_b (
    .Clk(Clk), .Rst(rst_b), .status(st_b),
    .display(disp_b), .anodeActivate(an_b), .frameStart(fs_b)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] disp;
    logic       fs;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  exp_t obs;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] glyph_of(input byte c);
    case (c)
      "E": return 7'b0110000;
      "n": return 7'b1101010;
      "t": return 7'b1110000;
      "P": return 7'b0011000;
      "r": return 7'b1111010;
      "G": return 7'b0100001;
      "o": return 7'b1100010;
      "S": return 7'b0100100;
      "O": return 7'b0000001;
      "-": return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic string msg_of(input logic [2:0] s);
    case (s)
      3'd0: return "    ";
      3'd1: return "EntP";
      3'd2: return "Err ";
      3'd3: return "Go  ";
      3'd4: return "StOP";
      default: return "----";
    endcase
  endfunction

  function automatic logic [6:0] char_glyph(input logic [2:0] s, input int k);
    string m;
    m = msg_of(s);
    return glyph_of(m[3-k]);
  endfunction

  // Expected outputs for one full frame: digit k held for div ticks, frameStart on the last tick.
  task automatic push_frame(input logic [2:0] s, input int div, input bit blank);
    exp_t x;
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < div; r++) begin
        x.an   = ~(4'b0001 << k);
        x.disp = blank ? 7'b1111111 : char_glyph(s, k);
        x.fs   = (k == 3) && (r == div - 1);
        sb_q.push_back(x);
      end
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b1; st_a = 3'd0;
    rst_b = 1'b1; st_b = 3'd0;
    repeat (3) begin @(posedge Clk); #1; end
    e = '{an: 4'b1111, disp: 7'b1111111, fs: 1'b0};
    obs = {an_a, disp_a, fs_a};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_a got an=%b disp=%b fs=%b expected an=%b disp=%b fs=%b", obs.an, obs.disp, obs.fs, e.an, e.disp, e.fs);
    end
    obs = {an_b, disp_b, fs_b};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_b got an=%b disp=%b fs=%b expected an=%b disp=%b fs=%b", obs.an, obs.disp, obs.fs, e.an, e.disp, e.fs);
    end
  endtask

  task automatic test_idle_scan;
    rst_a = 1'b0;
    push_frame(3'd0, 2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      obs = {an_a, disp_a, fs_a};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL idle_scan tick %0d got an=%b disp=%b fs=%b expected an=%b disp=%b fs=%b", i, obs.an, obs.disp, obs.fs, e.an, e.disp, e.fs);
      end
    end
  endtask

  task automatic test_entp;
    push_frame(3'd0, 2, 1'b0);
    push_frame(3'd1, 2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) st_a = 3'd1;
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      obs = {an_a, disp_a, fs_a};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL entp tick %0d got an=%b disp=%b fs=%b expected an=%b disp=%b fs=%b", i, obs.an, obs.disp, obs.fs, e.an, e.disp, e.fs);
      end
    end
  endtask

  task automatic test_stop_reserved;
    push_frame(3'd1, 2, 1'b0);
    push_frame(3'd4, 2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 1) st_a = 3'd4;
      if (i == 9) st_a = 3'd6;
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      obs = {an_a, disp_a, fs_a};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stop_reserved tick %0d got an=%b disp=%b fs=%b expected an=%b disp=%b fs=%b", i, obs.an, obs.disp, obs.fs, e.an, e.disp, e.fs);
      end
    end
  endtask

  task automatic test_no_tear;
    push_frame(3'd6, 2, 1'b0);
    push_frame(3'd3, 2, 1'b0);
    push_frame(3'd3, 2, 1'b0);
    for (int i = 0; i < 24; i++) begin
      if (i == 1 || i == 6 || i == 13) st_a = 3'd3;
      if (i == 3 || i == 10) st_a = 3'd2;
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      obs = {an_a, disp_a, fs_a};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL no_tear tick %0d got an=%b disp=%b fs=%b expected an=%b disp=%b fs=%b", i, obs.an, obs.disp, obs.fs, e.an, e.disp, e.fs);
      end
    end
  endtask

  task automatic test_mid_reset;
    exp_t x;
    for (int i = 0; i < 5; i++) begin
      x.an = ~(4'b0001 << (i / 2));
      x.disp = char_glyph(3'd3, i / 2);
      x.fs = 1'b0;
      sb_q.push_back(x);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      obs = {an_a, disp_a, fs_a};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mid_reset_pre tick %0d got an=%b disp=%b fs=%b expected an=%b disp=%b fs=%b", i, obs.an, obs.disp, obs.fs, e.an, e.disp, e.fs);
      end
    end
    rst_a = 1'b1;
    @(posedge Clk); #1;
    rst_a = 1'b0;
    e = '{an: 4'b1111, disp: 7'b1111111, fs: 1'b0};
    obs = {an_a, disp_a, fs_a};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL mid_reset_edge got an=%b disp=%b fs=%b expected an=%b disp=%b fs=%b", obs.an, obs.disp, obs.fs, e.an, e.disp, e.fs);
    end
    // Status stays 3 across the reset: first frame must still be IDLE.
    push_frame(3'd0, 2, 1'b0);
    push_frame(3'd3, 2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      obs = {an_a, disp_a, fs_a};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mid_reset_post tick %0d got an=%b disp=%b fs=%b expected an=%b disp=%b fs=%b", i, obs.an, obs.disp, obs.fs, e.an, e.disp, e.fs);
      end
    end
  endtask

  task automatic test_blink;
    bit hidden;
    st_b = 3'd2;
    rst_b = 1'b1;
    @(posedge Clk); #1;
    rst_b = 1'b0;
    push_frame(3'd0, 1, 1'b0);
    for (int f = 1; f <= 8; f++) begin
`ifdef CPS_BLINK_EN
      hidden = (((f - 1) / 2) % 2) == 1;
`else
      hidden = 1'b0;
`endif
      push_frame(3'd2, 1, hidden);
    end
    for (int i = 0; i < 36; i++) begin
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      obs = {an_b, disp_b, fs_b};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL blink tick %0d got an=%b disp=%b fs=%b expected an=%b disp=%b fs=%b", i, obs.an, obs.disp, obs.fs, e.an, e.disp, e.fs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_entp();
    test_stop_reserved();
    test_no_tear();
    test_mid_reset();
    test_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
